edulent_mem_responder: RTL and testbench

- Memory-side responder for the Edulent CPU data path: 256x8 single-port program/data RAM that answers the CPU's address, write-enable and write-data bus.
- Returns read data one cycle after the address.
- Adds a host loader (valid/ready byte stream) and a zero-fill engine. Both own the RAM port and hold the CPU via o_cpu_hold while active.

---
 rtl/edulent_mem_pkg.sv | 20 ++
 rtl/edulent_mem_responder_if.sv | 44 ++++
 rtl/edulent_ram_sp.sv | 31 +++
 rtl/edulent_mem_responder.sv | 125 ++++++++++++
 tb/tb_edulent_mem_responder.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/edulent_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : edulent_mem_pkg
//  Purpose  : Shared types and sizes for the Edulent memory responder.
//  Revision : 1.0  initial release
// ============================================================================
package edulent_mem_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 8;
    localparam int MEM_DEPTH  = 256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLEAR
    } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/edulent_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : edulent_mem_responder_if
//  Purpose  : CPU bus, host loader stream and control/status of the responder.
//  Revision : 1.0  initial release
// ============================================================================
interface edulent_mem_responder_if
    import edulent_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
);

    logic [ADDR_W-1:0] i_mem_addr;
    logic              i_mem_we;
    logic [DATA_W-1:0] i_mem_wdata;
    logic [DATA_W-1:0] o_mem_rdata;
    logic              i_ld_start;
    logic [ADDR_W-1:0] i_ld_base;
    logic [ADDR_W-1:0] i_ld_len;
    logic              i_ld_valid;
    logic [DATA_W-1:0] i_ld_data;
    logic              o_ld_ready;
    logic              i_clr_start;
    logic              o_cpu_hold;
    logic              o_done;
    logic [ADDR_W:0]   o_ld_count;

    modport slave (
        input  i_mem_addr, i_mem_we, i_mem_wdata,
        input  i_ld_start, i_ld_base, i_ld_len, i_ld_valid, i_ld_data,
        input  i_clr_start,
        output o_mem_rdata, o_ld_ready, o_cpu_hold, o_done, o_ld_count
    );

    modport master (
        output i_mem_addr, i_mem_we, i_mem_wdata,
        output i_ld_start, i_ld_base, i_ld_len, i_ld_valid, i_ld_data,
        output i_clr_start,
        input  o_mem_rdata, o_ld_ready, o_cpu_hold, o_done, o_ld_count
    );

endinterface
`default_nettype wire

// File: rtl/edulent_ram_sp.sv
`default_nettype none
// ============================================================================
//  Module   : edulent_ram_sp
//  Purpose  : Single-port synchronous RAM, read-first, array not reset.
//  Revision : 1.0  initial release
// ============================================================================
module edulent_ram_sp #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  wire logic              i_clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [DATA_W-1:0] i_wdata,
    output logic      [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/edulent_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : edulent_mem_responder
//  Purpose  : CPU-facing RAM with host byte loader and zero-fill engine.
//  Revision : 1.0  initial release
// ============================================================================
module edulent_mem_responder
    import edulent_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  wire logic              i_clk,
    input  wire logic              i_rst,
    edulent_mem_responder_if.slave bus
);

    localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   c_cnt_one  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   c_full_len = {1'b1, {ADDR_W{1'b0}}};

    mem_state_t        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [ADDR_W:0]   r_remain, w_remain_nxt;
    logic [ADDR_W:0]   r_ld_count, w_ld_count_nxt;
    logic              r_done, w_done_nxt;
    logic              r_rd_en;

    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [DATA_W-1:0] w_ram_q;

    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_remain_nxt   = r_remain;
        w_ld_count_nxt = r_ld_count;
        w_done_nxt     = 1'b0;
        w_ram_we       = 1'b0;
        w_ram_addr     = bus.i_mem_addr;
        w_ram_wdata    = bus.i_mem_wdata;

        case (r_state)
            ST_IDLE: begin
                w_ram_we = bus.i_mem_we;
                // Clear has priority; a coincident load request is dropped.
                if (bus.i_clr_start) begin
                    w_state_nxt = ST_CLEAR;
                    w_addr_nxt  = '0;
                end else if (bus.i_ld_start) begin
                    w_state_nxt    = ST_LOAD;
                    w_addr_nxt     = bus.i_ld_base;
                    w_remain_nxt   = (bus.i_ld_len == '0) ? c_full_len : {1'b0, bus.i_ld_len};
                    w_ld_count_nxt = '0;
                end
            end
            ST_LOAD: begin
                w_ram_addr  = r_addr;
                w_ram_wdata = bus.i_ld_data;
                if (bus.i_ld_valid) begin
                    w_ram_we       = 1'b1;
                    w_addr_nxt     = r_addr + c_addr_one;
                    w_remain_nxt   = r_remain - c_cnt_one;
                    w_ld_count_nxt = r_ld_count + c_cnt_one;
                    if (r_remain == c_cnt_one) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                w_ram_we    = 1'b1;
                w_ram_addr  = r_addr;
                w_ram_wdata = '0;
                w_addr_nxt  = r_addr + c_addr_one;
                if (&r_addr) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_remain   <= '0;
            r_ld_count <= '0;
            r_done     <= 1'b0;
            r_rd_en    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_remain   <= w_remain_nxt;
            r_ld_count <= w_ld_count_nxt;
            r_done     <= w_done_nxt;
            r_rd_en    <= (r_state == ST_IDLE);
        end
    end

    edulent_ram_sp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_ram_we & ~i_rst),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_q)
    );

    // The RAM output register has no reset, so read data is qualified here.
    assign bus.o_mem_rdata = r_rd_en ? w_ram_q : '0;
    assign bus.o_ld_ready  = (r_state == ST_LOAD);
    assign bus.o_cpu_hold  = (r_state != ST_IDLE);
    assign bus.o_done      = r_done;
    assign bus.o_ld_count  = r_ld_count;

endmodule
`default_nettype wire

// File: tb/tb_edulent_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_edulent_mem_responder
//  Purpose  : Scoreboard bench with a memory-array reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_edulent_mem_responder;

    typedef struct {
        int         due;
        logic [7:0] addr;
        logic [7:0] exp;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   last_count = 0;

    logic [7:0] model [256];
    bit         known [256];
    logic [7:0] ld_bytes [$];
    rd_t        rd_q [$];
    int         done_q [$];

    edulent_mem_responder_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    edulent_mem_responder #(.ADDR_W(8), .DATA_W(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon
        rd_t r;
        while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
            r = rd_q.pop_front();
            chk($sformatf("rdata[%02h]", r.addr), int'(bus.o_mem_rdata), int'(r.exp));
        end
        if (bus.o_done === 1'b1) begin
            if (done_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got=1 want=0 (cycle %0d)", cyc);
            end else begin
                chk("done_count", int'(bus.o_ld_count), done_q.pop_front());
                chk("done_hold", int'(bus.o_cpu_hold), 0);
            end
        end
    end

    task automatic cpu_cycle(input logic [7:0] a, input bit we, input logic [7:0] wd);
        bus.i_mem_addr  = a;
        bus.i_mem_we    = we;
        bus.i_mem_wdata = wd;
        if (known[a]) rd_q.push_back('{due: cyc + 1, addr: a, exp: model[a]});
        if (we) begin
            model[a] = wd;
            known[a] = 1'b1;
        end
        @(posedge clk); #1;
        bus.i_mem_we = 1'b0;
    endtask

    task automatic chk_in_load(input bit first);
        chk("ld_ready", int'(bus.o_ld_ready), 1);
        chk("ld_hold", int'(bus.o_cpu_hold), 1);
        if (!first) chk("ld_rdata", int'(bus.o_mem_rdata), 0);
    endtask

    // Loads ld_bytes; a CPU write to 0x05 is attempted throughout and must be dropped.
    task automatic do_load(input logic [7:0] base, input logic [7:0] len, input int stall_at,
                           input bit rand_stall, input int abort_after,
                           input bit cw, input logic [7:0] ca, input logic [7:0] cd);
        int n;
        int k;
        bit first;
        n = (len == 8'd0) ? 256 : int'(len);
        if (abort_after < 0) done_q.push_back(n);
        bus.i_ld_start  = 1'b1;
        bus.i_ld_base   = base;
        bus.i_ld_len    = len;
        bus.i_mem_addr  = ca;
        bus.i_mem_we    = cw;
        bus.i_mem_wdata = cd;
        if (cw) begin
            model[ca] = cd;
            known[ca] = 1'b1;
        end
        @(posedge clk); #1;
        bus.i_ld_start  = 1'b0;
        bus.i_mem_addr  = 8'h05;
        bus.i_mem_we    = 1'b1;
        bus.i_mem_wdata = 8'h77;
        last_count = 0;
        first = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i == abort_after) begin
                rst = 1'b1;
                bus.i_ld_valid = 1'b0;
                bus.i_mem_we = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                chk("abort_hold", int'(bus.o_cpu_hold), 0);
                chk("abort_ready", int'(bus.o_ld_ready), 0);
                chk("abort_count", int'(bus.o_ld_count), 0);
                chk("abort_rdata", int'(bus.o_mem_rdata), 0);
                repeat (3) @(posedge clk);
                #1;
                return;
            end
            k = (i == stall_at) ? 2 : (rand_stall ? int'($urandom_range(0, 1)) : 0);
            bus.i_ld_valid = 1'b0;
            repeat (k) begin
                chk_in_load(first);
                first = 1'b0;
                @(posedge clk); #1;
            end
            bus.i_ld_valid = 1'b1;
            bus.i_ld_data  = ld_bytes[i];
            chk_in_load(first);
            first = 1'b0;
            @(posedge clk); #1;
            model[8'(int'(base) + i)] = ld_bytes[i];
            known[8'(int'(base) + i)] = 1'b1;
            last_count = i + 1;
        end
        bus.i_ld_valid = 1'b0;
        bus.i_mem_we   = 1'b0;
        chk("ld_end_ready", int'(bus.o_ld_ready), 0);
        chk("ld_end_hold", int'(bus.o_cpu_hold), 0);
        chk("ld_end_count", int'(bus.o_ld_count), n);
    endtask

    task automatic do_clear(input bit with_ld);
        int cnt;
        cnt = 0;
        done_q.push_back(last_count);
        bus.i_clr_start = 1'b1;
        bus.i_ld_start  = with_ld;
        bus.i_ld_base   = 8'h20;
        bus.i_ld_len    = 8'd3;
        bus.i_mem_we    = 1'b0;
        @(posedge clk); #1;
        bus.i_clr_start = 1'b0;
        bus.i_ld_start  = 1'b0;
        bus.i_ld_valid  = 1'b1;
        bus.i_ld_data   = 8'hEE;
        while (bus.o_cpu_hold === 1'b1 && cnt < 300) begin
            chk("clr_ready", int'(bus.o_ld_ready), 0);
            cnt++;
            @(posedge clk); #1;
        end
        bus.i_ld_valid = 1'b0;
        chk("clr_cycles", cnt, 256);
        for (int a = 0; a < 256; a++) begin
            model[a] = 8'h00;
            known[a] = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.i_mem_addr  = '0;
        bus.i_mem_we    = 1'b0;
        bus.i_mem_wdata = '0;
        bus.i_ld_start  = 1'b0;
        bus.i_ld_base   = '0;
        bus.i_ld_len    = '0;
        bus.i_ld_valid  = 1'b0;
        bus.i_ld_data   = '0;
        bus.i_clr_start = 1'b0;
        for (int a = 0; a < 256; a++) known[a] = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_rdata", int'(bus.o_mem_rdata), 0);
        chk("rst_ready", int'(bus.o_ld_ready), 0);
        chk("rst_hold", int'(bus.o_cpu_hold), 0);
        chk("rst_done", int'(bus.o_done), 0);
        chk("rst_count", int'(bus.o_ld_count), 0);

        // Basic write/read and read-first collision
        cpu_cycle(8'h10, 1'b1, 8'hA5);
        cpu_cycle(8'h10, 1'b0, 8'h00);
        cpu_cycle(8'h10, 1'b1, 8'h3C);
        cpu_cycle(8'h10, 1'b0, 8'h00);
        cpu_cycle(8'h05, 1'b1, 8'h5A);

        // Wrapping load with a mid-stream stall
        ld_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_load(8'hFE, 8'd4, 2, 1'b0, -1, 1'b0, 8'h00, 8'h00);
        cpu_cycle(8'hFE, 1'b0, 8'h00);
        cpu_cycle(8'hFF, 1'b0, 8'h00);
        cpu_cycle(8'h00, 1'b0, 8'h00);
        cpu_cycle(8'h01, 1'b0, 8'h00);
        cpu_cycle(8'h05, 1'b0, 8'h00);

        // Reset after two bytes, then a fresh load
        ld_bytes = '{8'h61, 8'h62, 8'h63, 8'h64};
        do_load(8'h40, 8'd4, -1, 1'b0, 2, 1'b0, 8'h00, 8'h00);
        last_count = 0;
        cpu_cycle(8'h40, 1'b0, 8'h00);
        cpu_cycle(8'h41, 1'b0, 8'h00);
        ld_bytes = '{8'h71, 8'h72, 8'h73, 8'h74};
        do_load(8'h40, 8'd4, -1, 1'b1, -1, 1'b0, 8'h00, 8'h00);
        for (int a = 8'h40; a < 8'h44; a++) cpu_cycle(8'(a), 1'b0, 8'h00);

        // Full 256-byte load, RAM[i] = i
        ld_bytes.delete();
        for (int i = 0; i < 256; i++) ld_bytes.push_back(8'(i));
        do_load(8'h00, 8'd0, -1, 1'b0, -1, 1'b0, 8'h00, 8'h00);
        for (int a = 0; a < 256; a++) cpu_cycle(8'(a), 1'b0, 8'h00);

        // Clear and load requested together: clear wins
        do_clear(1'b1);
        for (int a = 0; a < 256; a++) cpu_cycle(8'(a), 1'b0, 8'h00);

        // Randomised CPU traffic interleaved with random loads
        for (int r = 0; r < 4; r++) begin
            int n;
            repeat (40) cpu_cycle(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 8'($urandom));
            n = int'($urandom_range(1, 20));
            ld_bytes.delete();
            for (int i = 0; i < n; i++) ld_bytes.push_back(8'($urandom));
            do_load(8'($urandom_range(0, 255)), 8'(n), -1, 1'b1, -1,
                    1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom));
            repeat (20) cpu_cycle(8'($urandom_range(0, 255)), 1'b0, 8'h00);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rd_q_drained", rd_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
